control_fsm: RTL

//   Multi-cycle successor to the single-cycle control decoder. Sequences each instruction through

---
 rtl/control_pkg.sv | 55 +++++
 rtl/opcode_classifier.sv | 41 ++++
 rtl/control_fsm.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
//   Shared definitions for the multi-cycle control FSM:
//     - opcode values (OP_ADD .. OP_MOV); 0x00-0x13 is the ALU range
//     - state_t, the FSM state encoding (also exported on the debug port)
//     - op_class_t, the coarse opcode classes produced by opcode_classifier
//     - MTR_* encodings for the writeback select (memory_to_register)
//     - is_store(), used to split the shared LOAD/STORE memory class
// ---------------------------------------------------------------------------
package control_pkg;

  localparam int unsigned OP_ADD      = 'h00;
  localparam int unsigned OP_ALU_LAST = 'h13;
  localparam int unsigned OP_LOAD     = 'h14;
  localparam int unsigned OP_STORE    = 'h15;
  localparam int unsigned OP_JUMP     = 'h16;
  localparam int unsigned OP_BEQ      = 'h17;
  localparam int unsigned OP_BNE      = 'h18;
  localparam int unsigned OP_NOP      = 'h19;
  localparam int unsigned OP_HALT     = 'h1A;
  localparam int unsigned OP_IN       = 'h1B;
  localparam int unsigned OP_OUT      = 'h1C;
  localparam int unsigned OP_MOV      = 'h1D;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_IN  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_IO_WAIT   = 3'd5,
    ST_HALTED    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_MOV,
    CLS_MEM,
    CLS_BRANCH,
    CLS_NOP,
    CLS_HALT,
    CLS_IN,
    CLS_OUT,
    CLS_ILLEGAL
  } op_class_t;

  function automatic logic is_store(input logic [31:0] op);
    return op == OP_STORE;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// ---------------------------------------------------------------------------
// opcode_classifier
//   Purely combinational opcode -> class decode. Keeping it separate lets the
//   FSM reason about a handful of classes instead of 64 opcodes, and lets the
//   disassembler bench reuse the same decode.
// Ports
//   opcode    in   OPCODE_WIDTH  raw opcode
//   op_class  out  op_class_t    ALU/MOV/MEM/BRANCH/NOP/HALT/IN/OUT/ILLEGAL
// ---------------------------------------------------------------------------
module opcode_classifier
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output op_class_t               op_class
);

  logic [31:0] op_ext;

  assign op_ext = 32'(opcode);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (op_ext <= OP_ALU_LAST) begin
      op_class = CLS_ALU;
    end else begin
      case (op_ext)
        OP_LOAD, OP_STORE:       op_class = CLS_MEM;
        OP_JUMP, OP_BEQ, OP_BNE: op_class = CLS_BRANCH;
        OP_NOP:                  op_class = CLS_NOP;
        OP_HALT:                 op_class = CLS_HALT;
        OP_IN:                   op_class = CLS_IN;
        OP_OUT:                  op_class = CLS_OUT;
        OP_MOV:                  op_class = CLS_MOV;
        default:                 op_class = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm
//   Multi-cycle control unit. Steps each instruction through
//   FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK (plus IO_WAIT for IN/OUT), stalls
//   on memory and I/O handshakes, and drives the datapath enables. HALT and
//   faults park the FSM in HALTED until reset.
//
// Configuration macro
//   CONTROL_FSM_ILLEGAL_TRAP_EN  defined: opcodes 0x1E-0x3F halt with fault.
//                                undefined: they behave as NOP.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   opcode                       IR opcode field, sampled in DECODE
//   mem_ready                    data memory done (looked at in MEMORY only)
//   in_valid / in_ready          input port handshake (IO_WAIT, IN)
//   out_valid / out_ready        output port handshake (IO_WAIT, OUT)
//   pc_write, ir_write           fetch enables
//   alu_code, target_register,
//   alu_source                   ALU control
//   write_register,
//   memory_to_register           register-file write strobe and source select
//   memory_read, memory_write    data memory strobes
//   branch                       branch/jump evaluate strobe
//   halt, fault                  sticky status
//   state                        current state for debug
// ---------------------------------------------------------------------------
module control_fsm
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH  = 6,
  parameter int MEM_TIMEOUT   = 16,
  parameter int TIMEOUT_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  input  logic                    in_valid,
  input  logic                    out_ready,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic [OPCODE_WIDTH-1:0] alu_code,
  output logic                    target_register,
  output logic                    alu_source,
  output logic                    write_register,
  output logic                    memory_write,
  output logic                    memory_read,
  output logic [1:0]              memory_to_register,
  output logic                    branch,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic                    halt,
  output logic                    fault,
  output logic [2:0]              state
);

  state_t                   state_q, state_d;
  logic [OPCODE_WIDTH-1:0]  op_q, op_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d, tmo_inc;
  logic                     fault_q, fault_d;

  op_class_t                dec_class;
  op_class_t                cur_class;

  logic                     pc_write_c, ir_write_c;
  logic [OPCODE_WIDTH-1:0]  alu_code_c;
  logic                     target_register_c, alu_source_c, write_register_c;
  logic                     memory_write_c, memory_read_c;
  logic [1:0]               memory_to_register_c;
  logic                     branch_c, in_ready_c, out_valid_c, halt_c;

  // Two classifiers: one looks at the live IR in DECODE, the other at the
  // latched opcode that steers every later state of the instruction.
  opcode_classifier #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_dec_class (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  opcode_classifier #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_cur_class (
    .opcode   (op_q),
    .op_class (cur_class)
  );

  assign tmo_inc = tmo_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    fault_d = fault_q;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;

      ST_DECODE: begin
        op_d = opcode;
        case (dec_class)
          CLS_ALU, CLS_MOV, CLS_MEM, CLS_BRANCH: state_d = ST_EXECUTE;
          CLS_HALT:                              state_d = ST_HALTED;
          CLS_IN, CLS_OUT:                       state_d = ST_IO_WAIT;
          CLS_ILLEGAL: begin
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            state_d = ST_HALTED;
            fault_d = 1'b1;
`else
            state_d = ST_FETCH;
`endif
          end
          default:                               state_d = ST_FETCH;
        endcase
      end

      ST_EXECUTE: begin
        case (cur_class)
          CLS_ALU, CLS_MOV: state_d = ST_WRITEBACK;
          CLS_MEM:          state_d = ST_MEMORY;
          default:          state_d = ST_FETCH;
        endcase
      end

      // The stall counter counts not-ready cycles; hitting MEM_TIMEOUT on a
      // not-ready cycle gives up. MEM_TIMEOUT == 0 disables the watchdog.
      ST_MEMORY: begin
        if (mem_ready) begin
          tmo_d   = '0;
          state_d = is_store(32'(op_q)) ? ST_FETCH : ST_WRITEBACK;
        end else if (MEM_TIMEOUT != 0) begin
          if (tmo_inc == TIMEOUT_WIDTH'(MEM_TIMEOUT)) begin
            tmo_d   = '0;
            state_d = ST_HALTED;
            fault_d = 1'b1;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end

      ST_WRITEBACK: state_d = ST_FETCH;

      ST_IO_WAIT: begin
        if (cur_class == CLS_IN) begin
          if (in_valid) state_d = ST_WRITEBACK;
        end else begin
          if (out_ready) state_d = ST_FETCH;
        end
      end

      ST_HALTED: state_d = ST_HALTED;

      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath controls decoded from the current state and latched opcode.
  // in_ready is the one handshake that also looks at its partner input, so
  // the word is consumed in the very cycle it is offered.
  always_comb begin
    pc_write_c           = 1'b0;
    ir_write_c           = 1'b0;
    alu_code_c           = '0;
    target_register_c    = 1'b0;
    alu_source_c         = 1'b0;
    write_register_c     = 1'b0;
    memory_write_c       = 1'b0;
    memory_read_c        = 1'b0;
    memory_to_register_c = MTR_ALU;
    branch_c             = 1'b0;
    in_ready_c           = 1'b0;
    out_valid_c          = 1'b0;
    halt_c               = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
      end

      ST_EXECUTE: begin
        case (cur_class)
          CLS_ALU: begin
            alu_code_c        = op_q;
            target_register_c = 1'b1;
          end
          CLS_MOV: alu_code_c = op_q;
          CLS_MEM: begin
            alu_code_c   = OPCODE_WIDTH'(OP_ADD);
            alu_source_c = 1'b1;
          end
          CLS_BRANCH: begin
            alu_code_c = op_q;
            branch_c   = 1'b1;
          end
          default: ;
        endcase
      end

      ST_MEMORY: begin
        if (is_store(32'(op_q))) memory_write_c = 1'b1;
        else                     memory_read_c  = 1'b1;
      end

      ST_WRITEBACK: begin
        write_register_c = 1'b1;
        if (cur_class == CLS_MEM)     memory_to_register_c = MTR_MEM;
        else if (cur_class == CLS_IN) memory_to_register_c = MTR_IN;
      end

      ST_IO_WAIT: begin
        if (cur_class == CLS_IN) in_ready_c  = in_valid;
        else                     out_valid_c = 1'b1;
      end

      ST_HALTED: halt_c = 1'b1;

      default: ;
    endcase
  end

  // Reset is synchronous, so the state register still holds the aborted
  // instruction during the reset cycle; force every output quiet here.
  assign pc_write           = ~reset & pc_write_c;
  assign ir_write           = ~reset & ir_write_c;
  assign alu_code           = reset ? '0 : alu_code_c;
  assign target_register    = ~reset & target_register_c;
  assign alu_source         = ~reset & alu_source_c;
  assign write_register     = ~reset & write_register_c;
  assign memory_write       = ~reset & memory_write_c;
  assign memory_read        = ~reset & memory_read_c;
  assign memory_to_register = reset ? MTR_ALU : memory_to_register_c;
  assign branch             = ~reset & branch_c;
  assign in_ready           = ~reset & in_ready_c;
  assign out_valid          = ~reset & out_valid_c;
  assign halt               = ~reset & halt_c;
  assign fault              = ~reset & fault_q;
  assign state              = reset ? 3'd0 : state_q;

endmodule
